// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial UART transmitter. One clk cycle is one bit time (clk is the baud
// clock). A byte accepted in IDLE is framed as: start bit (0), DATA_WIDTH data
// bits LSB first, optional parity bit, stop bit (1). Only one frame is in
// flight at a time; requests that arrive while a frame is on the line are
// dropped.
//
// Ports
//   clk         in   1           baud-rate clock, rising edge
//   rst         in   1           synchronous reset, active high
//   P_DATA      in   DATA_WIDTH  byte to send, sampled on acceptance only
//   Data_Valid  in   1           send request (pulsed or held)
//   PAR_EN      in   1           1 = append a parity bit
//   PAR_TYP     in   1           0 = even parity, 1 = odd parity
//   TX_OUT      out  1           serial line, registered, idles high
//   Busy        out  1           registered, high while a frame is on the line
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, waiting for Data_Valid; accepts and latches a byte
// START   | start bit (0) for one bit time
// DATA    | data_q[bit_cnt], bit_cnt = 0 .. DATA_WIDTH-1
// PARITY  | latched parity bit for one bit time (only if latched PAR_EN)
// STOP    | stop bit (1) for one bit time; requests here are ignored
//
// TX_OUT and Busy are registered copies of the value decoded from the current
// state, so the line lags the state register by one cycle. That lag is what
// places the start bit one edge after acceptance and guarantees one idle-high
// bit between back-to-back frames.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bit_q;
  logic                  par_en_q;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  accept;

  assign accept = (state == S_IDLE) && Data_Valid;

  // ---------------------------------------------------------------------------
  // State register, frame registers and output flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;

      // Frame settings are frozen at acceptance; later input changes are
      // invisible to the frame in flight.
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
      end

      // Held at zero outside DATA, so it is already cleared on entry.
      if (state == S_DATA) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Data_Valid) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_nxt = S_STOP;
      end
      S_STOP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered into TX_OUT / Busy above)
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
      S_START: begin
        tx_nxt = 1'b0;
      end
      S_DATA: begin
        tx_nxt = data_q[bit_cnt];
      end
      S_PARITY: begin
        tx_nxt = par_bit_q;
      end
      S_STOP: begin
        tx_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. Expected frames are written out by hand as bit
// strings in line order (start bit first). Outputs are sampled 1 time unit
// after each rising edge; inputs are driven at the same point so the DUT sees
// them at the following edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int vectors;
  int miscompares;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx"}, TX_OUT, 1'b1);
    chk({tag, " busy"}, Busy, 1'b0);
  endtask

  // One bit per cycle, in line order; Busy must be high for each of them.
  task automatic frame_bits(input string tag, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      step();
      chk($sformatf("%s bit%0d tx", tag, i), TX_OUT, bits[i] == 8'h31);
      chk($sformatf("%s bit%0d busy", tag, i), Busy, 1'b1);
    end
  endtask

  // Single-cycle request, then the whole frame, then the line back at idle.
  task automatic send(input string tag, input logic [7:0] d, input logic pen,
                      input logic ptyp, input string bits);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    // Acceptance edge just passed; start bit appears one edge later.
    chk_idle({tag, " accept"});
    frame_bits(tag, bits);
    step();
    chk_idle({tag, " after"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    P_DATA      = 8'h00;
    Data_Valid  = 1'b0;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;

    // Reset idle
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // 0xA5 without parity: start, 1,0,1,0,0,1,0,1, stop
    send("a5_nopar", 8'hA5, 1'b0, 1'b0, "0101001011");

    // 0xA5 even parity (four ones -> 0), odd parity -> 1
    send("a5_even", 8'hA5, 1'b1, 1'b0, "01010010101");
    send("a5_odd",  8'hA5, 1'b1, 1'b1, "01010010111");
    // 0x07 even parity (three ones -> 1)
    send("07_even", 8'h07, 1'b1, 1'b0, "01110000011");

    // Request while busy: 0x3C = 0,0,1,1,1,1,0,0 LSB first. 0xFF pulses land
    // on edges where the FSM is in DATA (after index 3) and STOP (after index 8).
    begin
      string exp_3c;
      exp_3c     = "0001111001";
      P_DATA     = 8'h3C;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      chk_idle("3c accept");
      for (int i = 0; i < exp_3c.len(); i++) begin
        step();
        chk($sformatf("3c bit%0d tx", i), TX_OUT, exp_3c[i] == 8'h31);
        chk($sformatf("3c bit%0d busy", i), Busy, 1'b1);
        if (i == 3 || i == 8) begin
          P_DATA     = 8'hFF;
          PAR_EN     = 1'b1;
          PAR_TYP    = 1'b1;
          Data_Valid = 1'b1;
        end else begin
          Data_Valid = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        step();
        chk_idle($sformatf("3c after%0d", i));
      end
    end

    // Held Data_Valid: 0x55 then 0x81, exactly one idle-high bit between.
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    P_DATA     = 8'h55;
    Data_Valid = 1'b1;
    step();
    P_DATA = 8'h81;
    chk_idle("held accept1");
    frame_bits("held55", "0101010101");
    step();
    chk_idle("held gap");
    frame_bits("held81", "0100000011");
    Data_Valid = 1'b0;
    step();
    chk_idle("held after");
    step();
    chk_idle("held after2");

    // Reset mid-frame: 0x00 frame, reset while data bit 3 is on the line.
    P_DATA     = 8'h00;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    frame_bits("zero", "00000");
    rst        = 1'b1;
    P_DATA     = 8'hC3;
    Data_Valid = 1'b1;
    step();
    chk_idle("midrst");
    rst        = 1'b0;
    Data_Valid = 1'b0;
    step();
    chk_idle("midrst post1");
    step();
    chk_idle("midrst post2");

    // 0xC3 = 1,1,0,0,0,0,1,1 LSB first
    send("c3", 8'hC3, 1'b0, 1'b0, "0110000111");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
